seven_seg_scan_ctrl: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 15 +
 rtl/seven_seg_scan_ctrl_hex_to_seg.sv | 11 +
 rtl/seven_seg_scan_ctrl.sv | 99 +++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants, segment table and display record for the scan controller
package seven_seg_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank_mask;
    } disp_t;
endpackage

// File: rtl/seven_seg_scan_ctrl_hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low seven-segment pattern
//   hex in  [3:0]  nibble to display
//   seg out [6:0]  {g,f,e,d,c,b,a}, active-low
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[hex];
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: 4-digit multiplexed seven-segment scan controller with frame-aligned loads
//   clk, rst (sync, active-high)
//   load_valid/load_ready : handshake for value[15:0], dp_in[3:0], blank_mask[3:0]
//   an[3:0]   : anode selects, active-low
//   seg[6:0]  : segments {g,f,e,d,c,b,a}, active-low
//   dp        : decimal point, active-low
//   frame_tick: one-cycle pulse after each completed frame
//   Optional: define LEADING_ZERO_BLANK_EN to suppress leading zero digits 3..1
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK    = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    disp_t         disp_q, disp_d, pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_tick_q, frame_tick_d;
    logic [6:0]    seg_w;
    logic          wrap, boundary, accept, zsup, lit;

    hex_to_seg u_hex (
        .hex(disp_q.value[{idx_q, 2'b00} +: 4]),
        .seg(seg_w)
    );

    always_comb begin
        wrap         = cnt_q == CNT_LAST;
        boundary     = wrap && idx_q == 2'd3;
        accept       = load_valid && !pend_full_q;
        cnt_d        = wrap ? '0 : cnt_q + 1'b1;
        idx_d        = wrap ? idx_q + 2'd1 : idx_q;
        pend_d       = accept ? disp_t'{value, dp_in, blank_mask} : pend_q;
        // Only a value already pending before the boundary is applied;
        // accept and apply are exclusive since accept needs an empty buffer.
        disp_d       = boundary && pend_full_q ? pend_q : disp_q;
        pend_full_d  = accept ? 1'b1 : boundary ? 1'b0 : pend_full_q;
`ifdef LEADING_ZERO_BLANK_EN
        zsup         = idx_q != 2'd0 && (disp_q.value >> {idx_q, 2'b00}) == 16'h0;
`else
        zsup         = 1'b0;
`endif
        lit          = cnt_q >= BLANK && !disp_q.blank_mask[idx_q] && !zsup;
        an_d         = lit ? ~(4'b0001 << idx_q) : AN_OFF;
        seg_d        = lit ? seg_w : SEG_BLANK;
        dp_d         = lit ? ~disp_q.dp[idx_q] : 1'b1;
        frame_tick_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign load_ready = !pend_full_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed self-checking bench for seven_seg_scan_ctrl (CLK_DIV=4, BLANK_CYCLES=1)
module tb_seven_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
    int          n;
    int          passed = 0;
    int          total = 0;

    // Expected anodes for edge n, indexed by (n-1)%16 after reset release
    logic [3:0] an_pat [16] = '{
        4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101,
        4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b0111
    };

    seven_seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .value(value), .dp_in(dp_in), .blank_mask(blank_mask),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    task automatic do_reset(input logic lv);
        rst = 1'b1;
        load_valid = lv;
        value = 16'hBEEF;
        repeat (3) step();
        rst = 1'b0;
        load_valid = 1'b0;
        n = 0;
    endtask

    // Offer one load so that it is sampled at edge n+1
    task automatic offer(input logic [15:0] v, input logic [3:0] d, input logic [3:0] bm);
        value = v;
        dp_in = d;
        blank_mask = bm;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        total++;
        if ({an, seg, dp, load_ready, frame_tick} !== {4'b1111, 7'h7F, 1'b1, 1'b1, 1'b0})
            $display("FAIL reset_outputs: got an=%b seg=%h dp=%b rdy=%b ft=%b, want 1111 7f 1 1 0", an, seg, dp, load_ready, frame_tick);
        else passed++;
        do_reset(1'b1);
        total++;
        if ({an, seg, dp, load_ready} !== {4'b1111, 7'h7F, 1'b1, 1'b1})
            $display("FAIL reset_with_valid: got an=%b seg=%h dp=%b rdy=%b, want 1111 7f 1 1", an, seg, dp, load_ready);
        else passed++;
        step();
        total++;
        if (load_ready !== 1'b1) $display("FAIL reset_no_capture: got rdy=%b want 1", load_ready);
        else passed++;
    endtask

    task automatic test_scan();
        logic [3:0] ea;
        do_reset(1'b0);
        for (int k = 1; k <= 32; k++) begin
            step();
            ea = an_pat[(n - 1) % 16];
            total++;
            if ({an, seg, dp, frame_tick} !== {ea, (ea == 4'b1111) ? 7'h7F : 7'h40, 1'b1, n % 16 == 0})
                $display("FAIL scan n=%0d: got an=%b seg=%h dp=%b ft=%b, want an=%b", n, an, seg, dp, frame_tick, ea);
            else passed++;
        end
    endtask

    task automatic test_load();
        do_reset(1'b0);
        run_to(5);
        offer(16'h1234, 4'b0001, 4'b0000);
        total++;
        if ({load_ready, seg} !== {1'b0, 7'h40})
            $display("FAIL load_pending: got rdy=%b seg=%h, want 0 40", load_ready, seg);
        else passed++;
        run_to(16);
        total++;
        if ({frame_tick, load_ready} !== 2'b11)
            $display("FAIL load_boundary: got ft=%b rdy=%b, want 1 1", frame_tick, load_ready);
        else passed++;
        run_to(18);
        total++;
        if ({an, seg, dp} !== {4'b1110, 7'h19, 1'b0})
            $display("FAIL load_digit0: got an=%b seg=%h dp=%b, want 1110 19 0", an, seg, dp);
        else passed++;
        run_to(22);
        total++;
        if ({an, seg, dp} !== {4'b1101, 7'h30, 1'b1})
            $display("FAIL load_digit1: got an=%b seg=%h dp=%b, want 1101 30 1", an, seg, dp);
        else passed++;
        run_to(26);
        total++;
        if ({an, seg, dp} !== {4'b1011, 7'h24, 1'b1})
            $display("FAIL load_digit2: got an=%b seg=%h dp=%b, want 1011 24 1", an, seg, dp);
        else passed++;
        run_to(30);
        total++;
        if ({an, seg, dp} !== {4'b0111, 7'h79, 1'b1})
            $display("FAIL load_digit3: got an=%b seg=%h dp=%b, want 0111 79 1", an, seg, dp);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        run_to(5);
        offer(16'h1234, 4'b0000, 4'b0000);
        run_to(7);
        value = 16'hFFFF;
        load_valid = 1'b1;
        run_to(10);
        load_valid = 1'b0;
        run_to(18);
        total++;
        if ({an, seg} !== {4'b1110, 7'h19})
            $display("FAIL ignore_while_busy: got an=%b seg=%h, want 1110 19", an, seg);
        else passed++;
        run_to(20);
        total++;
        if (load_ready !== 1'b1) $display("FAIL ignore_no_capture: got rdy=%b want 1", load_ready);
        else passed++;
        do_reset(1'b0);
        run_to(15);
        offer(16'h5678, 4'b0000, 4'b0000);
        total++;
        if ({frame_tick, load_ready} !== 2'b10)
            $display("FAIL boundary_accept: got ft=%b rdy=%b, want 1 0", frame_tick, load_ready);
        else passed++;
        run_to(18);
        total++;
        if ({an, seg} !== {4'b1110, 7'h40})
            $display("FAIL boundary_deferred: got an=%b seg=%h, want 1110 40", an, seg);
        else passed++;
        run_to(32);
        total++;
        if (load_ready !== 1'b1) $display("FAIL boundary_ready: got rdy=%b want 1", load_ready);
        else passed++;
        run_to(34);
        total++;
        if ({an, seg} !== {4'b1110, 7'h00})
            $display("FAIL boundary_applied: got an=%b seg=%h, want 1110 00", an, seg);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        run_to(5);
        offer(16'hAAAA, 4'b1111, 4'b0000);
        run_to(9);
        rst = 1'b1;
        step();
        total++;
        if ({an, seg, dp, load_ready, frame_tick} !== {4'b1111, 7'h7F, 1'b1, 1'b1, 1'b0})
            $display("FAIL reset_mid: got an=%b seg=%h dp=%b rdy=%b ft=%b, want 1111 7f 1 1 0", an, seg, dp, load_ready, frame_tick);
        else passed++;
        step();
        rst = 1'b0;
        n = 0;
        run_to(18);
        total++;
        if ({an, seg, dp} !== {4'b1110, 7'h40, 1'b1})
            $display("FAIL reset_discard: got an=%b seg=%h dp=%b, want 1110 40 1", an, seg, dp);
        else passed++;
    endtask

    task automatic test_blanking();
        do_reset(1'b0);
        run_to(1);
        offer(16'h0042, 4'b0000, 4'b0100);
        run_to(18);
        total++;
        if ({an, seg} !== {4'b1110, 7'h24})
            $display("FAIL blank_digit0: got an=%b seg=%h, want 1110 24", an, seg);
        else passed++;
        run_to(22);
        total++;
        if ({an, seg} !== {4'b1101, 7'h19})
            $display("FAIL blank_digit1: got an=%b seg=%h, want 1101 19", an, seg);
        else passed++;
        for (int k = 26; k <= 28; k++) begin
            run_to(k);
            total++;
            if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1})
                $display("FAIL blank_mask_digit2 n=%0d: got an=%b seg=%h dp=%b, want 1111 7f 1", n, an, seg, dp);
            else passed++;
        end
        run_to(30);
        total++;
`ifdef LEADING_ZERO_BLANK_EN
        if ({an, seg} !== {4'b1111, 7'h7F})
            $display("FAIL zero_blank_digit3: got an=%b seg=%h, want 1111 7f", an, seg);
        else passed++;
`else
        if ({an, seg} !== {4'b0111, 7'h40})
            $display("FAIL zero_lit_digit3: got an=%b seg=%h, want 0111 40", an, seg);
        else passed++;
`endif
    endtask

    initial begin
        n = 0;
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_reset_mid();
        test_blanking();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
